// File: rtl/fwd_pipe_ctrl.sv
// In-flight destination/result tracker: forwards the youngest ready result to decode, raises load-use stalls, drives writeback.
// Decode-to-writeback takes DEPTH cycles; mem_stall freezes every entry and stalls decode.
module fwd_pipe_ctrl #(
   parameter int DATA_WIDTH         = 64,
   parameter int REG_ADDRESS_LENGTH = 5,
   parameter int DEPTH              = 3,
   parameter int LOAD_STAGE         = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          id_valid,
   input  logic                          id_wen,
   input  logic                          id_load,
   input  logic [REG_ADDRESS_LENGTH-1:0] id_rd,
   input  logic [REG_ADDRESS_LENGTH-1:0] id_ra,
   input  logic [REG_ADDRESS_LENGTH-1:0] id_rb,
   input  logic                          id_ra_used,
   input  logic                          id_rb_used,
   input  logic                          id_flush,
   input  logic [DATA_WIDTH-1:0]         ex_result,
   input  logic [DATA_WIDTH-1:0]         mem_data,
   input  logic                          mem_stall,
   output logic                          fwd_a_sel,
   output logic                          fwd_b_sel,
   output logic [DATA_WIDTH-1:0]         fwd_a_data,
   output logic [DATA_WIDTH-1:0]         fwd_b_data,
   output logic                          stall,
   output logic                          wb_en,
   output logic [REG_ADDRESS_LENGTH-1:0] wb_addr,
   output logic [DATA_WIDTH-1:0]         wb_data,
   output logic [31:0]                   stall_count
);

   typedef struct packed {
      logic                          vld;
      logic                          wen;
      logic                          load;
      logic                          rdy;
      logic [REG_ADDRESS_LENGTH-1:0] rd;
      logic [DATA_WIDTH-1:0]         dat;
   } ent_t;

   // Index 0 is entry 1 (youngest), index DEPTH-1 feeds writeback.
   ent_t ent_q [DEPTH];
   ent_t ent_d [DEPTH];

   logic                  dec_live;
   logic                  hit_a, hit_b, rdy_a, rdy_b, hazard;
   logic [DATA_WIDTH-1:0] dat_a, dat_b;

   assign dec_live = id_valid & ~id_flush;

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      rdy_a = 1'b0;
      rdy_b = 1'b0;
      dat_a = '0;
      dat_b = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (dec_live && id_ra_used && ent_q[k].vld && ent_q[k].wen && ent_q[k].rd == id_ra) begin
            hit_a = 1'b1;
            rdy_a = ent_q[k].rdy;
            dat_a = ent_q[k].dat;
         end
         if (dec_live && id_rb_used && ent_q[k].vld && ent_q[k].wen && ent_q[k].rd == id_rb) begin
            hit_b = 1'b1;
            rdy_b = ent_q[k].rdy;
            dat_b = ent_q[k].dat;
         end
      end
   end

   assign hazard     = (hit_a & ~rdy_a) | (hit_b & ~rdy_b);
   assign stall      = hazard | mem_stall;
   assign fwd_a_sel  = hit_a & rdy_a;
   assign fwd_b_sel  = hit_b & rdy_b;
   assign fwd_a_data = (hit_a & rdy_a) ? dat_a : '0;
   assign fwd_b_data = (hit_b & rdy_b) ? dat_b : '0;

   // ALU results are captured leaving entry 1, load data leaving entry LOAD_STAGE.
   always_comb begin
      ent_d[0]      = '0;
      ent_d[0].vld  = dec_live & ~hazard;
      ent_d[0].wen  = id_wen;
      ent_d[0].load = id_load;
      ent_d[0].rd   = id_rd;
      for (int k = 1; k < DEPTH; k++) begin
         ent_d[k] = ent_q[k-1];
         if (k == 1 && !ent_q[k-1].load) begin
            ent_d[k].dat = ex_result;
            ent_d[k].rdy = 1'b1;
         end
         if (k == LOAD_STAGE && ent_q[k-1].load) begin
            ent_d[k].dat = mem_data;
            ent_d[k].rdy = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
         stall_count <= '0;
      end else begin
         if (stall && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
         if (!mem_stall) begin
            for (int k = 0; k < DEPTH; k++) ent_q[k] <= ent_d[k];
         end
      end
   end

   assign wb_en   = ent_q[DEPTH-1].vld & ent_q[DEPTH-1].wen;
   assign wb_addr = ent_q[DEPTH-1].rd;
   assign wb_data = ent_q[DEPTH-1].dat;

endmodule

// File: doc/fwd_pipe_ctrl.md
# fwd_pipe_ctrl

Parametrised in-flight instruction tracker that sits between decode and register-file writeback in the integer pipeline. It holds DEPTH stages of destination and result state and forwards the youngest ready result to both decode operands. It detects load-use and not-yet-computed hazards and generates the decode stall. It also absorbs data-memory back-pressure and counts stall cycles.

## Interface
- DATA_WIDTH, 64, operand/result width
- REG_ADDRESS_LENGTH, 5, register address width
- DEPTH, 3, number of in-flight entries (2..8); entry DEPTH drives writeback
- LOAD_STAGE, 1, entry index whose outgoing transfer captures load data (1..DEPTH-1)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- id_valid  input  1  decode slot holds a real instruction
- id_wen  input  1  decode instruction writes a register
- id_load  input  1  decode instruction is a load
- id_rd  input  REG_ADDRESS_LENGTH  decode destination
- id_ra, id_rb  input  REG_ADDRESS_LENGTH  decode source addresses
- id_ra_used, id_rb_used  input  1  source is actually read
- id_flush  input  1  discard decode instruction (branch taken)
- ex_result  input  DATA_WIDTH  ALU result of the entry-1 instruction
- mem_data  input  DATA_WIDTH  load data of the entry-LOAD_STAGE instruction
- mem_stall  input  1  data memory not ready; freeze all entries
- fwd_a_sel, fwd_b_sel  output  1  use forwarded data instead of register file
- fwd_a_data, fwd_b_data  output  DATA_WIDTH  forwarded value
- stall  output  1  hold PC and IF/ID register this cycle
- wb_en  output  1  register-file write enable
- wb_addr  output  REG_ADDRESS_LENGTH  write address
- wb_data  output  DATA_WIDTH  write data
- stall_count  output  32  saturating count of stalled cycles

## Operation
- Each entry k (1..DEPTH) holds: valid, wen, load, rd, rdy, data.
- Advance (when not frozen): entry k+1 takes entry k. Entry 1 takes the decode instruction, or a bubble (valid=0) if id_valid=0, id_flush=1, or a hazard is present.
  - Entry 1→2 transfer of a non-load: data=ex_result, rdy=1.
  - Entry LOAD_STAGE→LOAD_STAGE+1 transfer of a load: data=mem_data, rdy=1.
  - Every other transfer copies data and rdy unchanged. Entry 1 always has rdy=0.
- Match for source X: id_X_used and id_valid and !id_flush, and an entry with valid, wen and rd==id_X. Register 0 is not special. The youngest (lowest k) matching entry wins.
- If the youngest match has rdy=1: fwd_X_sel=1 and fwd_X_data=its data. Otherwise fwd_X_sel=0 and fwd_X_data=0.
- Hazard: the youngest match for A or B has rdy=0.
- stall = hazard | mem_stall.
- Freeze: mem_stall=1 holds every entry and ignores id_flush. The flush source holds id_flush until it is accepted.
- Writeback: wb_en = valid&wen of entry DEPTH; wb_addr and wb_data come from entry DEPTH. A load reaching DEPTH is always rdy by construction.
- stall_count increments on each cycle with stall=1 and saturates at 2^32-1.

## Timing
- Reset (rst=0, asynchronous): all valid=0, rdy=0, data=0. wb_en=0, wb_addr=0, wb_data=0, stall_count=0. fwd_*_sel=0, fwd_*_data=0, stall=0 (no inputs pending).
- fwd_*, stall and the hazard signal are combinational from entry state and id_* inputs in the same cycle. wb_* are direct register outputs.
- Decode-to-writeback latency is DEPTH cycles without stalls.
- Load-use distance d (consumer issued d cycles after the load) stalls for max(0, LOAD_STAGE+1-d) cycles.
- ALU-use consumer at distance 1 stalls 1 cycle. Forwarding is available from entry 2 onward.
- Entry DEPTH is included in matching, so no register-file write/read collision window exists.
- Simultaneous hazard and id_flush: the flush wins, stall=0, and a bubble is inserted.
- Simultaneous mem_stall and hazard: frozen with stall=1. The hazard is re-evaluated after the freeze ends.
- Reset deassertion mid-stream: the pipeline restarts empty. The first wb_en is no earlier than DEPTH cycles after the first accepted instruction.

## Test plan
- Defaults: issue r3←ALU (ex_result=0x11), then r3-reader on the next cycle → stall=1 for 1 cycle. Then fwd_a_sel=1, fwd_a_data=0x11. wb r3=0x11 3 cycles after issue.
- Defaults: load r5 (mem_data=0xAB), consumer at distance 1 → 1 stall cycle, then fwd_b_data=0xAB. Consumer at distance 2 → no stall.
- Two in-flight writes to r7 (0x1 older, 0x2 younger), then a reader → fwd_a_data=0x2.
- mem_stall held 4 cycles mid-stream → entries and wb_* unchanged. stall_count rises by 4. Flush asserted during the freeze takes effect on the first unfrozen cycle.
- DEPTH=5, LOAD_STAGE=3: load, then immediate consumer → 3 stall cycles. wb 5 cycles after issue.
- Assert rst=0 with 3 valid entries → wb_en=0 and stall_count=0 immediately, without a clock edge.
